// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl
//   Sequences a level-to-level palette change:
//   fade out -> swap palette bank -> hold black -> fade in.
//   It also scales the palette ROM colour by the current brightness, with one
//   register stage.
//
//   Brightness steps once every FRAMES_PER_STEP vsync pulses. After the bank
//   swap it stays black for HOLD_FRAMES vsync pulses.
//
//   Optional feature: define PALETTE_FADE_ABORT_EN to add the 'abort' input.
//   Abort turns a fade-out, or the black hold, straight into a fade-in.
//
// Ports
//   Clk, Reset_n                  pixel clock, async active-low reset
//   vsync_pulse                   one-cycle start-of-frame strobe
//   req_valid/req_level/req_ready level-change request handshake
//   abort                         (PALETTE_FADE_ABORT_EN only) cut a fade short
//   red_in/green_in/blue_in       palette ROM colour (4b each)
//   red_out/green_out/blue_out    brightness-scaled colour, registered
//   level_sel                     palette bank select
//   fade_level                    current brightness 0..15
//   busy                          transition in progress
//   done                          one-cycle pulse when a request completes
`timescale 1ns/1ps

module palette_fade_ctrl #(
    parameter int LEVEL_W         = 2,
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               vsync_pulse,
    input  logic               req_valid,
    input  logic [LEVEL_W-1:0] req_level,
    output logic               req_ready,
`ifdef PALETTE_FADE_ABORT_EN
    input  logic               abort,
`endif
    input  logic [3:0]         red_in,
    input  logic [3:0]         green_in,
    input  logic [3:0]         blue_in,
    output logic [3:0]         red_out,
    output logic [3:0]         green_out,
    output logic [3:0]         blue_out,
    output logic [LEVEL_W-1:0] level_sel,
    output logic [3:0]         fade_level,
    output logic               busy,
    output logic               done
);

    // A single counter is used for the step cadence and for the black hold.
    localparam int CNT_MAX = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FADE_OUT,
        S_HOLD,
        S_FADE_IN
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   frame_cnt, next_frame_cnt;
    logic [3:0]         next_fade_level;
    logic [LEVEL_W-1:0] next_level_sel;
    logic [LEVEL_W-1:0] target_level, next_target_level;
    logic               next_done;
    logic               abort_now;

`ifdef PALETTE_FADE_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    // Computes c*f/15 using only shifts: p = c*f, out = (p + p/16 + 8) / 16.
    // f=15 returns c unchanged, and f=0 returns 0.
    function automatic logic [3:0] scale_channel(input logic [3:0] c, input logic [3:0] f);
        logic [7:0] p;
        p = {4'b0, c} * {4'b0, f};
        return 4'((p + {4'b0, p[7:4]} + 8'd8) >> 4);
    endfunction

    assign busy      = (state != S_IDLE);
    assign req_ready = (state == S_IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            frame_cnt    <= '0;
            fade_level   <= 4'd15;
            level_sel    <= '0;
            target_level <= '0;
            done         <= 1'b0;
        end else begin
            state        <= next_state;
            frame_cnt    <= next_frame_cnt;
            fade_level   <= next_fade_level;
            level_sel    <= next_level_sel;
            target_level <= next_target_level;
            done         <= next_done;
        end
    end

    always_comb begin
        next_state        = state;
        next_frame_cnt    = frame_cnt;
        next_fade_level   = fade_level;
        next_level_sel    = level_sel;
        next_target_level = target_level;
        next_done         = 1'b0;

        unique case (state)
            S_IDLE: begin
                // A vsync in the accept cycle is not counted, because the counter starts at 0.
                if (req_valid) begin
                    next_target_level = req_level;
                    if (req_level == level_sel) begin
                        next_done = 1'b1;
                    end else begin
                        next_state     = S_FADE_OUT;
                        next_frame_cnt = '0;
                    end
                end
            end

            S_FADE_OUT: begin
                if (abort_now) begin
                    next_state     = S_FADE_IN;
                    next_frame_cnt = '0;
                end else if (vsync_pulse) begin
                    if (frame_cnt == STEP_LAST) begin
                        next_frame_cnt = '0;
                        if (fade_level != 4'd0) begin
                            next_fade_level = fade_level - 4'd1;
                        end
                        // The bank swaps on the same edge that reaches black,
                        // so the new palette is never shown at a non-zero brightness.
                        if (fade_level <= 4'd1) begin
                            next_state     = S_HOLD;
                            next_level_sel = target_level;
                        end
                    end else begin
                        next_frame_cnt = frame_cnt + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (abort_now) begin
                    next_state     = S_FADE_IN;
                    next_frame_cnt = '0;
                end else if (vsync_pulse) begin
                    if (frame_cnt == HOLD_LAST) begin
                        next_state     = S_FADE_IN;
                        next_frame_cnt = '0;
                    end else begin
                        next_frame_cnt = frame_cnt + 1'b1;
                    end
                end
            end

            S_FADE_IN: begin
                // Already at full brightness happens only after an early abort.
                if (fade_level == 4'd15) begin
                    next_state = S_IDLE;
                    next_done  = 1'b1;
                end else if (vsync_pulse) begin
                    if (frame_cnt == STEP_LAST) begin
                        next_frame_cnt  = '0;
                        next_fade_level = fade_level + 4'd1;
                        if (fade_level == 4'd14) begin
                            next_state = S_IDLE;
                            next_done  = 1'b1;
                        end
                    end else begin
                        next_frame_cnt = frame_cnt + 1'b1;
                    end
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ---- colour stage: ROM colour -> scaled output register ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_out   <= 4'd0;
            green_out <= 4'd0;
            blue_out  <= 4'd0;
        end else begin
            red_out   <= scale_channel(red_in, fade_level);
            green_out <= scale_channel(green_in, fade_level);
            blue_out  <= scale_channel(blue_in, fade_level);
        end
    end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
`timescale 1ns/1ps

module tb_palette_fade_ctrl;

    localparam int LEVEL_W = 2;
    localparam int FPS     = 2;
    localparam int HOLD    = 4;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b1;
    logic               vsync_pulse = 1'b0;
    logic               req_valid = 1'b0;
    logic [LEVEL_W-1:0] req_level = '0;
    logic               req_ready;
`ifdef PALETTE_FADE_ABORT_EN
    logic               abort = 1'b0;
`endif
    logic [3:0]         red_in = '0, green_in = '0, blue_in = '0;
    logic [3:0]         red_out, green_out, blue_out;
    logic [LEVEL_W-1:0] level_sel;
    logic [3:0]         fade_level;
    logic               busy, done;

    palette_fade_ctrl #(
        .LEVEL_W(LEVEL_W), .FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .vsync_pulse(vsync_pulse),
        .req_valid(req_valid), .req_level(req_level), .req_ready(req_ready),
`ifdef PALETTE_FADE_ABORT_EN
        .abort(abort),
`endif
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .level_sel(level_sel), .fade_level(fade_level), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] r, g, b, fade;
        logic [1:0] lsel;
        logic       busy, ready, done;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: the phase plus the number of vsyncs seen in that phase.
    // Brightness follows from that with plain division.
    int m_mode;   // 0 idle, 1 fading out, 2 black hold, 3 fading in
    int m_base, m_k, m_lsel, m_target;

    function automatic int m_fade();
        int f;
        case (m_mode)
            1:       f = m_base - m_k / FPS;
            2:       f = 0;
            3:       f = m_base + m_k / FPS;
            default: f = 15;
        endcase
        if (f < 0) f = 0;
        if (f > 15) f = 15;
        return f;
    endfunction

    function automatic int exp_scale(input int c, input int f);
        int p;
        p = c * f;
        return (p + p / 16 + 8) / 16;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_base = 15; m_k = 0; m_lsel = 0; m_target = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus and queues the response expected after the next edge.
    task automatic drive_cycle(input bit rn, input bit v, input int lvl, input bit vs,
                               input int r, input int g, input int b, input bit ab);
        exp_t e;
        int   f0;
        bit   dn;
        @(negedge Clk);
        Reset_n     = rn;
        req_valid   = v;
        req_level   = LEVEL_W'(lvl);
        vsync_pulse = vs;
        red_in      = 4'(r);
        green_in    = 4'(g);
        blue_in     = 4'(b);
`ifdef PALETTE_FADE_ABORT_EN
        abort       = ab;
`endif
        if (!rn) begin
            m_reset();
            e.r = 0; e.g = 0; e.b = 0; e.fade = 15; e.lsel = 0;
            e.busy = 0; e.ready = 1; e.done = 0;
        end else begin
            f0  = m_fade();
            e.r = 4'(exp_scale(r, f0));
            e.g = 4'(exp_scale(g, f0));
            e.b = 4'(exp_scale(b, f0));
            dn  = 0;
            case (m_mode)
                0: if (v) begin
                    m_target = lvl;
                    if (lvl == m_lsel) dn = 1;
                    else begin m_mode = 1; m_base = 15; m_k = 0; end
                end
                1, 2: if (ab) begin
                    m_base = m_fade(); m_mode = 3; m_k = 0;
                end else if (vs) begin
                    m_k++;
                    if (m_mode == 1 && m_fade() == 0) begin
                        m_mode = 2; m_k = 0; m_lsel = m_target;
                    end else if (m_mode == 2 && m_k == HOLD) begin
                        m_mode = 3; m_base = 0; m_k = 0;
                    end
                end
                3: if (m_fade() == 15) begin
                    m_mode = 0; dn = 1;
                end else if (vs) begin
                    m_k++;
                    if (m_fade() == 15) begin m_mode = 0; dn = 1; end
                end
                default: ;
            endcase
            e.fade  = 4'(m_fade());
            e.lsel  = 2'(m_lsel);
            e.busy  = (m_mode != 0);
            e.ready = (m_mode == 0);
            e.done  = dn;
        end
        q.push_back(e);
    endtask

    // Monitor: the outputs are valid every cycle, so it pops one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("red_out",    32'(red_out),    32'(e.r));
                chk("green_out",  32'(green_out),  32'(e.g));
                chk("blue_out",   32'(blue_out),   32'(e.b));
                chk("fade_level", 32'(fade_level), 32'(e.fade));
                chk("level_sel",  32'(level_sel),  32'(e.lsel));
                chk("busy",       32'(busy),       32'(e.busy));
                chk("req_ready",  32'(req_ready),  32'(e.ready));
                chk("done",       32'(done),       32'(e.done));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nv, guard, sv_lsel, rr;
        m_reset();
        #1 Reset_n = 1'b0;
        #1;
        chk("async_reset_fade", 32'(fade_level), 32'd15);
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Idle passthrough at full brightness.
        drive_cycle(1, 0, 0, 0, 15, 0, 8, 0);
        @(posedge Clk); #2;
        chk("idle_red", 32'(red_out), 32'd15);
        chk("idle_blue", 32'(blue_out), 32'd8);

        // A request for the current level completes at once.
        chk("eq_ready", 32'(req_ready), 32'd1);
        drive_cycle(1, 1, 0, 0, 3, 4, 5, 0);
        @(posedge Clk); #2;
        chk("eq_done", 32'(done), 32'd1);
        chk("eq_fade", 32'(fade_level), 32'd15);
        drive_cycle(1, 0, 0, 0, 3, 4, 5, 0);
        @(posedge Clk); #2;
        chk("eq_done_clear", 32'(done), 32'd0);

        // Full transition to level 1. The vsync in the accept cycle must be ignored.
        drive_cycle(1, 1, 1, 1, 1, 2, 3, 0);
        for (int n = 1; n <= 64; n++) begin
            drive_cycle(1, (n % 2), 3, 1, $urandom_range(15), $urandom_range(15), $urandom_range(15), 0);
            @(posedge Clk); #2;
            if (n == 30) begin
                chk("v30_fade", 32'(fade_level), 32'd0);
                chk("v30_lsel", 32'(level_sel), 32'd1);
            end
            if (n == 34) chk("v34_fade", 32'(fade_level), 32'd0);
            if (n == 36) chk("v36_fade", 32'(fade_level), 32'd1);
            if (n == 64) begin
                chk("v64_fade", 32'(fade_level), 32'd15);
                chk("v64_done", 32'(done), 32'd1);
            end
            if (n != 64 && m_fade() == 7) begin
                drive_cycle(1, 0, 0, 0, 15, 0, 0, 0);
                @(posedge Clk); #2;
                chk("f7_red_F", 32'(red_out), 32'd7);
                drive_cycle(1, 0, 0, 0, 8, 0, 0, 0);
                @(posedge Clk); #2;
                chk("f7_red_8", 32'(red_out), 32'd4);
                drive_cycle(1, 0, 0, 0, 1, 0, 0, 0);
                @(posedge Clk); #2;
                chk("f7_red_1", 32'(red_out), 32'd0);
            end else if (n != 64) begin
                drive_cycle(1, 1, 2, 0, $urandom_range(15), 0, 0, 0);
            end
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk); #2;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a fade-out.
        drive_cycle(1, 1, 2, 0, 0, 0, 0, 0);
        guard = 0;
        while (m_fade() != 5 && guard < 100) begin
            drive_cycle(1, 0, 0, 1, 9, 9, 9, 0);
            guard++;
        end
        @(posedge Clk); #3;
        chk("pre_rst_fade", 32'(fade_level), 32'd5);
        Reset_n = 1'b0;
        #1;
        chk("rst_fade", 32'(fade_level), 32'd15);
        chk("rst_lsel", 32'(level_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_red", 32'(red_out), 32'd0);
        repeat (2) drive_cycle(0, 0, 0, 1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            rr = 0;
`ifdef PALETTE_FADE_ABORT_EN
            rr = ($urandom_range(39) == 0);
`endif
            drive_cycle(1, ($urandom_range(7) == 0), $urandom_range(3), ($urandom_range(3) == 0),
                        $urandom_range(15), $urandom_range(15), $urandom_range(15), rr[0]);
        end

`ifdef PALETTE_FADE_ABORT_EN
        // Abort at brightness 9 during the fade-out.
        guard = 0;
        while (m_mode != 0 && guard < 400) begin
            drive_cycle(1, 0, 0, 1, 5, 5, 5, 0);
            guard++;
        end
        sv_lsel = m_lsel;
        drive_cycle(1, 1, (m_lsel + 1) % 4, 0, 5, 5, 5, 0);
        guard = 0;
        while (m_fade() != 9 && guard < 100) begin
            drive_cycle(1, 0, 0, 1, 5, 5, 5, 0);
            guard++;
        end
        drive_cycle(1, 0, 0, 0, 5, 5, 5, 1);
        nv = 0;
        while (m_mode != 0 && nv < 50) begin
            drive_cycle(1, 0, 0, 1, 5, 5, 5, 0);
            nv++;
        end
        @(posedge Clk); #2;
        chk("abort_vsyncs", 32'(nv), 32'd12);
        chk("abort_lsel", 32'(level_sel), 32'(sv_lsel));
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_fade", 32'(fade_level), 32'd15);
`else
        nv = 0;
        sv_lsel = 0;
`endif

        repeat (3) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
